// File: rtl/control_pipe.sv
// ID/EX control stage: decodes RV32I (optionally M) into a registered control bundle,
// inserting load-use bubbles and raising a fetch/decode stall while they are pending.
module control_pipe #(
  parameter int XLEN                  = 32,
  parameter bit EN_M                  = 1'b0,
  parameter int LOAD_USE_STALL_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       instr_i,
  input  logic              instr_valid_i,
  input  logic              inhibit_control_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              hazard_stall_o,
  output logic              ctrl_valid_o,
  output logic              reg_write_o,
  output logic [1:0]        alu_op_o,
  output logic              alu_src_o,
  output logic              mem_read_o,
  output logic [XLEN/8-1:0] mem_write_o,
  output logic              mem_to_reg_o,
  output logic              is_branch_o,
  output logic              is_jump_o,
  output logic              is_muldiv_o,
  output logic              illegal_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [2:0]        funct3_o
);

  localparam int SW = XLEN / 8;
  localparam logic [2:0] BUBBLE_RELOAD = 3'(LOAD_USE_STALL_CYCLES - 1);

  typedef enum logic [4:0] {
    OPC_LOAD   = 5'b00000,
    OPC_OP_IMM = 5'b00100,
    OPC_AUIPC  = 5'b00101,
    OPC_STORE  = 5'b01000,
    OPC_OP     = 5'b01100,
    OPC_LUI    = 5'b01101,
    OPC_BRANCH = 5'b11000,
    OPC_JALR   = 5'b11001,
    OPC_JAL    = 5'b11011
  } opcode_e;

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic [1:0]    alu_op;
    logic          alu_src;
    logic          mem_read;
    logic [SW-1:0] mem_write;
    logic          mem_to_reg;
    logic          is_branch;
    logic          is_jump;
    logic          is_muldiv;
    logic          illegal;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    funct3;
  } ctrl_t;

  opcode_e    opcode;
  logic [2:0] funct3;
  ctrl_t      dec;
  ctrl_t      ex;
  logic       bad;
  logic       rs1_used;
  logic       rs2_used;
  logic       detect;
  logic [2:0] count;

  assign opcode = opcode_e'(instr_i[6:2]);
  assign funct3 = instr_i[14:12];

  // NOTE: every variable gets a default at the top of the block, so no path leaves one unassigned (no latch).
  always_comb begin
    dec = '0;
    bad = 1'b0;
    if (instr_i[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          dec.reg_write  = 1'b1;
          dec.alu_op     = 2'b10;
          dec.mem_to_reg = 1'b1;
          if (instr_i[31:25] == 7'b0000001) begin
            if (EN_M) dec.is_muldiv = 1'b1;
            else      bad = 1'b1;
          end
        end
        OPC_OP_IMM: begin
          dec.reg_write  = 1'b1;
          dec.alu_op     = 2'b10;
          dec.alu_src    = 1'b1;
          dec.mem_to_reg = 1'b1;
        end
        OPC_LOAD: begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.mem_read  = 1'b1;
          case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ;
            3'b011:  bad = (XLEN != 64);
            default: bad = 1'b1;
          endcase
        end
        OPC_STORE: begin
          dec.alu_src = 1'b1;
          case (funct3)
            3'b000:  dec.mem_write[0]   = 1'b1;
            3'b001:  dec.mem_write[1:0] = 2'b11;
            3'b010:  dec.mem_write[3:0] = 4'b1111;
            3'b011:  if (XLEN == 64) dec.mem_write = '1; else bad = 1'b1;
            default: bad = 1'b1;
          endcase
        end
        OPC_BRANCH: begin
          dec.alu_op    = 2'b01;
          dec.is_branch = 1'b1;
          if (funct3 == 3'b010 || funct3 == 3'b011) bad = 1'b1;
        end
        OPC_JAL, OPC_JALR: begin
          dec.reg_write  = 1'b1;
          dec.is_jump    = 1'b1;
          dec.alu_src    = 1'b1;
          dec.mem_to_reg = 1'b1;
        end
        OPC_LUI, OPC_AUIPC: begin
          dec.reg_write  = 1'b1;
          dec.alu_src    = 1'b1;
          dec.mem_to_reg = 1'b1;
        end
        default: bad = 1'b1;
      endcase
    end
    // Illegal instructions drop every control field but still carry their register indices.
    if (bad) dec = '0;
    dec.valid   = 1'b1;
    dec.illegal = bad & instr_valid_i;
    dec.rd      = instr_i[11:7];
    dec.rs1     = instr_i[19:15];
    dec.rs2     = instr_i[24:20];
    dec.funct3  = funct3;
  end

  assign rs1_used = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign rs2_used = opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};

  assign detect = instr_valid_i & ex.valid & ex.mem_read & (ex.rd != 5'd0) &
                  ((rs1_used & (dec.rs1 == ex.rd)) | (rs2_used & (dec.rs2 == ex.rd)));

  assign hazard_stall_o = detect | (count != 3'd0);

  // NOTE: state registers use non-blocking assignments and an asynchronous clear; reset wins over every other input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex    <= '0;
      count <= '0;
    end else if (flush_i) begin
      ex    <= '0;
      count <= '0;
    end else if (!stall_i) begin
      if (detect) begin
        ex    <= '0;
        count <= BUBBLE_RELOAD;
      end else if (count != 3'd0) begin
        ex    <= '0;
        count <= count - 3'd1;
      end else if (inhibit_control_i || !instr_valid_i) begin
        ex <= '0;
      end else begin
        ex <= dec;
      end
    end
  end

  assign ctrl_valid_o = ex.valid;
  assign reg_write_o  = ex.reg_write;
  assign alu_op_o     = ex.alu_op;
  assign alu_src_o    = ex.alu_src;
  assign mem_read_o   = ex.mem_read;
  assign mem_write_o  = ex.mem_write;
  assign mem_to_reg_o = ex.mem_to_reg;
  assign is_branch_o  = ex.is_branch;
  assign is_jump_o    = ex.is_jump;
  assign is_muldiv_o  = ex.is_muldiv;
  assign illegal_o    = ex.illegal;
  assign rd_o         = ex.rd;
  assign rs1_o        = ex.rs1;
  assign rs2_o        = ex.rs2;
  assign funct3_o     = ex.funct3;

endmodule
